// File: rtl/seg7_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : seg7_pkg
//  Purpose  : Shared definitions for the seven-segment scan driver. Holds the
//             active-low segment codes {a,b,c,d,e,f,g} and the scan state
//             encoding.
//  Revision : 1.0 - initial release
// ============================================================================
package seg7_pkg;

    // Scan state encoding
    typedef enum logic [1:0] {
        ST_OFF   = 2'd0,
        ST_BLANK = 2'd1,
        ST_SHOW  = 2'd2
    } state_t;

    // Active-low segment codes, bit order {a,b,c,d,e,f,g}
    localparam logic [6:0] c_SEG_0     = 7'b0000001;
    localparam logic [6:0] c_SEG_1     = 7'b1001111;
    localparam logic [6:0] c_SEG_2     = 7'b0010010;
    localparam logic [6:0] c_SEG_3     = 7'b0000110;
    localparam logic [6:0] c_SEG_4     = 7'b1001100;
    localparam logic [6:0] c_SEG_5     = 7'b0100100;
    localparam logic [6:0] c_SEG_6     = 7'b0100000;
    localparam logic [6:0] c_SEG_7     = 7'b0001111;
    localparam logic [6:0] c_SEG_8     = 7'b0000000;
    localparam logic [6:0] c_SEG_9     = 7'b0000100;
    localparam logic [6:0] c_SEG_A     = 7'b0001000;
    localparam logic [6:0] c_SEG_B     = 7'b1100000;
    localparam logic [6:0] c_SEG_C     = 7'b0110001;
    localparam logic [6:0] c_SEG_D     = 7'b1000010;
    localparam logic [6:0] c_SEG_E     = 7'b0110000;
    localparam logic [6:0] c_SEG_F     = 7'b0111000;
    localparam logic [6:0] c_SEG_DASH  = 7'b1111110;
    localparam logic [6:0] c_SEG_BLANK = 7'b1111111;

endpackage : seg7_pkg
`default_nettype wire

// File: rtl/seg7_digit_decoder.sv
`default_nettype none
// ============================================================================
//  Module   : seg7_digit_decoder
//  Purpose  : Combinational nibble to seven-segment decoder (active-low code).
//  Ports    : i_nibble   - digit value 0..15
//             i_hex_mode - 1: show 0-F, 0: BCD with 10-15 shown as a dash
//             o_code     - active-low segment code {a,b,c,d,e,f,g}
//  Revision : 1.0 - initial release
// ============================================================================
module seg7_digit_decoder
    import seg7_pkg::*;
(
    input  logic [3:0] i_nibble,
    input  logic       i_hex_mode,
    output logic [6:0] o_code
);

    always_comb begin
        o_code = c_SEG_DASH;
        case (i_nibble)
            4'h0:    o_code = c_SEG_0;
            4'h1:    o_code = c_SEG_1;
            4'h2:    o_code = c_SEG_2;
            4'h3:    o_code = c_SEG_3;
            4'h4:    o_code = c_SEG_4;
            4'h5:    o_code = c_SEG_5;
            4'h6:    o_code = c_SEG_6;
            4'h7:    o_code = c_SEG_7;
            4'h8:    o_code = c_SEG_8;
            4'h9:    o_code = c_SEG_9;
            4'hA:    o_code = i_hex_mode ? c_SEG_A : c_SEG_DASH;
            4'hB:    o_code = i_hex_mode ? c_SEG_B : c_SEG_DASH;
            4'hC:    o_code = i_hex_mode ? c_SEG_C : c_SEG_DASH;
            4'hD:    o_code = i_hex_mode ? c_SEG_D : c_SEG_DASH;
            4'hE:    o_code = i_hex_mode ? c_SEG_E : c_SEG_DASH;
            4'hF:    o_code = i_hex_mode ? c_SEG_F : c_SEG_DASH;
            default: o_code = c_SEG_DASH;
        endcase
    end

endmodule : seg7_digit_decoder
`default_nettype wire

// File: rtl/seg7_scan_driver.sv
`default_nettype none
// ============================================================================
//  Module   : seg7_scan_driver
//  Purpose  : Time-multiplexed driver for an N-digit common-anode display.
//             Captures a nibble vector into a shadow register and lights one
//             digit per slot, each slot opening with an all-off dead time.
//  Ports    : clk, rst     - clock, asynchronous active-high reset
//             load         - capture digits_in / dp_in this edge
//             digits_in    - nibble k = digit k (digit 0 rightmost)
//             dp_in        - decimal point request per digit
//             hex_mode     - 1: 0-F, 0: BCD with dash for 10-15
//             lz_suppress  - 1: blank leading zero digits
//             enable       - 0: display dark, scan held at digit 0
//             seg, dp, an  - registered segment, decimal point, digit select
//  Revision : 1.0 - initial release
// ============================================================================
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS     = 4,
    parameter int SCAN_DIV       = 100000,
    parameter int BLANK_CYCLES   = 4,
    parameter int SEG_ACTIVE_LOW = 1,
    parameter int AN_ACTIVE_LOW  = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] digits_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic                    hex_mode,
    input  logic                    lz_suppress,
    input  logic                    enable,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic [NUM_DIGITS-1:0]   an
);

    localparam int c_CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int c_IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [c_CNT_W-1:0]    c_CNT_LAST  = c_CNT_W'(SCAN_DIV - 1);
    localparam logic [c_CNT_W-1:0]    c_BLANK_END = c_CNT_W'(BLANK_CYCLES);
    localparam logic [c_IDX_W-1:0]    c_IDX_LAST  = c_IDX_W'(NUM_DIGITS - 1);
    localparam logic                  c_NO_BLANK  = (BLANK_CYCLES == 0);
    localparam logic [6:0]            c_SEG_OFF   = (SEG_ACTIVE_LOW != 0) ? c_SEG_BLANK : ~c_SEG_BLANK;
    localparam logic                  c_DP_OFF    = (SEG_ACTIVE_LOW != 0);
    localparam logic [NUM_DIGITS-1:0] c_AN_OFF    = (AN_ACTIVE_LOW != 0) ? '1 : '0;

    state_t                  r_state, w_state_nxt;
    logic [c_CNT_W-1:0]      r_cnt, w_cnt_nxt, w_cnt_inc;
    logic [c_IDX_W-1:0]      r_idx, w_idx_nxt, w_idx_inc;
    logic                    w_show_entry;
    logic                    w_hold;

    logic [4*NUM_DIGITS-1:0] r_digits, w_digits_eff;
    logic [NUM_DIGITS-1:0]   r_dps, w_dps_eff;
    logic [NUM_DIGITS-1:0]   w_sup;
    logic                    w_run_zero;
    logic [3:0]              w_nibble;
    logic [6:0]              w_code;
    logic [NUM_DIGITS-1:0]   w_an_sel;

    logic [6:0]              r_seg, w_seg_nxt;
    logic                    r_dp, w_dp_nxt;
    logic [NUM_DIGITS-1:0]   r_an, w_an_nxt;

    assign w_cnt_inc = r_cnt + c_CNT_W'(1);
    assign w_idx_inc = (r_idx == c_IDX_LAST) ? '0 : r_idx + c_IDX_W'(1);

    // A load on the same edge as a SHOW entry is forwarded so the entry
    // never shows stale data.
    assign w_digits_eff = load ? digits_in : r_digits;
    assign w_dps_eff    = load ? dp_in     : r_dps;

    // Shadow register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_digits <= '0;
            r_dps    <= '0;
        end else if (load) begin
            r_digits <= digits_in;
            r_dps    <= dp_in;
        end
    end

    // Scan state, slot counter and digit index
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_OFF;
            r_cnt   <= '0;
            r_idx   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_idx   <= w_idx_nxt;
        end
    end

    // Next-state logic. w_show_entry flags the edge on which a digit is
    // latched; w_hold flags edges where the lit digit must be kept.
    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_idx_nxt    = r_idx;
        w_show_entry = 1'b0;
        w_hold       = 1'b0;
        if (!enable) begin
            w_state_nxt = ST_OFF;
            w_cnt_nxt   = '0;
            w_idx_nxt   = '0;
        end else begin
            case (r_state)
                ST_OFF: begin
                    w_cnt_nxt = '0;
                    w_idx_nxt = '0;
                    if (c_NO_BLANK) begin
                        w_state_nxt  = ST_SHOW;
                        w_show_entry = 1'b1;
                    end else begin
                        w_state_nxt = ST_BLANK;
                    end
                end
                ST_BLANK: begin
                    w_cnt_nxt = w_cnt_inc;
                    if (w_cnt_inc == c_BLANK_END) begin
                        w_state_nxt  = ST_SHOW;
                        w_show_entry = 1'b1;
                    end
                end
                ST_SHOW: begin
                    if (r_cnt == c_CNT_LAST) begin
                        w_cnt_nxt = '0;
                        w_idx_nxt = w_idx_inc;
                        if (c_NO_BLANK) begin
                            w_show_entry = 1'b1;
                        end else begin
                            w_state_nxt = ST_BLANK;
                        end
                    end else begin
                        w_cnt_nxt = w_cnt_inc;
                        w_hold    = 1'b1;
                    end
                end
                default: begin
                    w_state_nxt = ST_OFF;
                    w_cnt_nxt   = '0;
                    w_idx_nxt   = '0;
                end
            endcase
        end
    end

    // Digit k is a leading zero when it and every higher nibble are zero.
    always_comb begin
        w_sup      = '0;
        w_run_zero = 1'b1;
        for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
            w_run_zero = w_run_zero && (w_digits_eff[4*k +: 4] == 4'd0);
            w_sup[k]   = lz_suppress && w_run_zero;
        end
    end

    assign w_nibble = w_digits_eff[{w_idx_nxt, 2'b00} +: 4];
    assign w_an_sel = NUM_DIGITS'(1) << w_idx_nxt;

    seg7_digit_decoder u_decoder (
        .i_nibble   (w_nibble),
        .i_hex_mode (hex_mode),
        .o_code     (w_code)
    );

    // Output values for the next edge
    always_comb begin
        w_seg_nxt = c_SEG_OFF;
        w_dp_nxt  = c_DP_OFF;
        w_an_nxt  = c_AN_OFF;
        if (w_show_entry) begin
            if (!w_sup[w_idx_nxt]) begin
                w_seg_nxt = (SEG_ACTIVE_LOW != 0) ? w_code : ~w_code;
                w_dp_nxt  = w_dps_eff[w_idx_nxt] ? ~c_DP_OFF : c_DP_OFF;
                w_an_nxt  = (AN_ACTIVE_LOW != 0) ? ~w_an_sel : w_an_sel;
            end
        end else if (w_hold) begin
            w_seg_nxt = r_seg;
            w_dp_nxt  = r_dp;
            w_an_nxt  = r_an;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_seg <= c_SEG_OFF;
            r_dp  <= c_DP_OFF;
            r_an  <= c_AN_OFF;
        end else begin
            r_seg <= w_seg_nxt;
            r_dp  <= w_dp_nxt;
            r_an  <= w_an_nxt;
        end
    end

    assign seg = r_seg;
    assign dp  = r_dp;
    assign an  = r_an;

endmodule : seg7_scan_driver
`default_nettype wire
